// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline controller: opcodes, ALU function codes,
// scoreboard geometry and the instruction decode table.
package pipeline_ctrl_pkg;

  localparam int SB_DEPTH = 4;
  localparam int REG_W    = 3;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_AND  = 5'b00010,
    OP_OR   = 5'b00011,
    OP_SLT  = 5'b00100,
    OP_ADDI = 5'b01000,
    OP_LW   = 5'b01001,
    OP_SW   = 5'b01010,
    OP_BEQ  = 5'b01011,
    OP_J    = 5'b10000,
    OP_NOP  = 5'b11111
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100,
    ALU_BEQ = 3'b101
  } alufn_e;

  typedef struct packed {
    logic       nia;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic [2:0] alu_fn;
    logic       use_a;
    logic       use_b;
    logic       illegal;
  } decode_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
  } sb_entry_t;

  // Unknown opcodes decode to an all-zero NOP with the illegal flag raised.
  function automatic decode_t decode_op(input logic [4:0] op_fn);
    decode_t d;
    d = '0;
    case (op_fn)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        d.reg_dst   = 1'b1;
        d.reg_write = 1'b1;
        d.alu_fn    = op_fn[2:0];
        d.use_a     = 1'b1;
        d.use_b     = 1'b1;
      end
      OP_ADDI: begin
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
        d.alu_fn    = ALU_ADD;
        d.use_a     = 1'b1;
      end
      OP_LW: begin
        d.alu_src    = 1'b1;
        d.reg_write  = 1'b1;
        d.mem_read   = 1'b1;
        d.mem_to_reg = 1'b1;
        d.alu_fn     = ALU_ADD;
        d.use_a      = 1'b1;
      end
      OP_SW: begin
        d.alu_src   = 1'b1;
        d.mem_write = 1'b1;
        d.alu_fn    = ALU_ADD;
        d.use_a     = 1'b1;
        d.use_b     = 1'b1;
      end
      OP_BEQ: begin
        d.alu_fn = ALU_BEQ;
        d.use_a  = 1'b1;
        d.use_b  = 1'b1;
      end
      OP_J: begin
        d.nia = 1'b1;
      end
      OP_NOP: begin
        d = '0;
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decoder-to-controller bundle: instruction fields in, stage-1 controls and
// hazard status out.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic [4:0]       OpFn;
  logic [REG_W-1:0] Ra;
  logic [REG_W-1:0] Rb;
  logic [REG_W-1:0] Rd;
  logic             alubeq;

  logic             NIA;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrc;
  logic             MemWrite;
  logic             MemRead;
  logic             MemToReg;
  logic [2:0]       ALUFn;
  logic             stall;
  logic             illegal;
  logic [1:0]       busy_cnt;

  modport master (
    output OpFn, Ra, Rb, Rd, alubeq,
    input  NIA, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg,
    input  ALUFn, stall, illegal, busy_cnt
  );

  modport slave (
    input  OpFn, Ra, Rb, Rd, alubeq,
    output NIA, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg,
    output ALUFn, stall, illegal, busy_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_scoreboard.sv
// Destination scoreboard for stages 2-5 and the source comparators that flag
// read-after-write hazards against it.
module hazard_scoreboard
  import pipeline_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [REG_W-1:0] load_dest,
  input  logic [REG_W-1:0] src_a,
  input  logic             use_a,
  input  logic [REG_W-1:0] src_b,
  input  logic             use_b,
  output logic             hit
);

  sb_entry_t [SB_DEPTH-1:0] sb_r;

  // Shift every cycle; entry 0 takes the issued destination (invalid on bubble).
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_r <= '0;
    end else begin
      sb_r[0].valid <= load_valid;
      sb_r[0].dest  <= load_dest;
      for (int i = 1; i < SB_DEPTH; i++) begin
        sb_r[i] <= sb_r[i-1];
      end
    end
  end

  // Register 0 is compared like any other register.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_r[i].valid && ((use_a && (sb_r[i].dest == src_a)) ||
                            (use_b && (sb_r[i].dest == src_b)))) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage-1 controller: decodes the instruction, holds it on RAW hazards or
// during the two-bubble branch wait, and flags illegal opcodes.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  decode_t          dec_s;
  decode_t          ctrl_s;
  logic [REG_W-1:0] dest_s;
  logic             raw_s;
  logic             stall_s;
  logic             issue_s;
  logic [1:0]       busy_r;
  logic             illegal_r;

  assign dec_s  = decode_op(bus.OpFn);
  assign dest_s = dec_s.reg_dst ? bus.Rd : bus.Rb;

  hazard_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .load_valid (issue_s & dec_s.reg_write),
    .load_dest  (dest_s),
    .src_a      (bus.Ra),
    .use_a      (dec_s.use_a),
    .src_b      (bus.Rb),
    .use_b      (dec_s.use_b),
    .hit        (raw_s)
  );

  // Branch wait outranks the RAW check; nothing stalls or issues during reset.
  always_comb begin
    stall_s = 1'b0;
    issue_s = 1'b0;
    if (rst) begin
      stall_s = 1'b0;
    end else if (busy_r != 2'd0) begin
      stall_s = 1'b1;
    end else if (raw_s) begin
      stall_s = 1'b1;
    end else begin
      issue_s = 1'b1;
    end
  end

  assign ctrl_s = issue_s ? dec_s : '0;

  // Branch-wait counter and sticky illegal-opcode flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r    <= 2'd0;
      illegal_r <= 1'b0;
    end else begin
      if (busy_r != 2'd0) begin
        busy_r <= busy_r - 2'd1;
      end else if (issue_s && (bus.OpFn == OP_BEQ)) begin
        busy_r <= 2'd2;
      end else begin
        busy_r <= busy_r;
      end
      if (dec_s.illegal) begin
        illegal_r <= 1'b1;
      end else begin
        illegal_r <= illegal_r;
      end
    end
  end

  assign bus.NIA      = ctrl_s.nia;
  assign bus.RegDst   = ctrl_s.reg_dst;
  assign bus.RegWrite = ctrl_s.reg_write;
  assign bus.ALUSrc   = ctrl_s.alu_src;
  assign bus.MemWrite = ctrl_s.mem_write;
  assign bus.MemRead  = ctrl_s.mem_read;
  assign bus.MemToReg = ctrl_s.mem_to_reg;
  assign bus.ALUFn    = ctrl_s.alu_fn;
  assign bus.stall    = stall_s;
  assign bus.illegal  = illegal_r;
  assign bus.busy_cnt = busy_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus a randomized run checked
// against a timestamp-based model of hazards and branch waits.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Model state: cycle index of the latest writer of each register and of
  // the latest issued BEQ; hazards are judged by cycle distance.
  int   now = 0;
  int   last_wr [8];
  int   beq_at;
  logic ill_m;

  logic [9:0] obs_ctrl, exp_ctrl;
  logic       obs_stall, exp_stall, obs_ill, exp_ill;
  logic [1:0] obs_busy, exp_busy;

  localparam logic [9:0] CTRL_ADD = 10'b0110000000;
  localparam logic [4:0] OPC_BEQ  = 5'b01011;

  logic [4:0] legal_ops [11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd9,
                                 5'd10, 5'd11, 5'd16, 5'd31};

  // {NIA, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, ALUFn}
  function automatic logic [9:0] ref_ctrl(input logic [4:0] op);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4: return {7'b0110000, op[2:0]};
      5'd8:  return {7'b0011000, 3'b000};
      5'd9:  return {7'b0011011, 3'b000};
      5'd10: return {7'b0001100, 3'b000};
      5'd11: return {7'b0000000, 3'b101};
      5'd16: return {7'b1000000, 3'b000};
      default: return 10'd0;
    endcase
  endfunction

  // {reads Ra, reads Rb}
  function automatic logic [1:0] ref_uses(input logic [4:0] op);
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 5'd11: return 2'b11;
      5'd8, 5'd9: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [4:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    foreach (last_wr[i]) last_wr[i] = -100;
    beq_at = -100;
    ill_m  = 1'b0;
  endtask

  task automatic sample();
    obs_ctrl  = {bus.NIA, bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.MemWrite,
                 bus.MemRead, bus.MemToReg, bus.ALUFn};
    obs_stall = bus.stall;
    obs_busy  = bus.busy_cnt;
    obs_ill   = bus.illegal;
  endtask

  task automatic apply(input logic [4:0] op, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] rd);
    int diff;
    logic [9:0] c;
    logic [1:0] u;
    logic raw;
    @(negedge clk);
    rst = 1'b0;
    bus.OpFn = op; bus.Ra = ra; bus.Rb = rb; bus.Rd = rd;
    bus.alubeq = 1'($urandom_range(1));
    #1;
    sample();
    diff = now - beq_at;
    exp_busy  = (diff >= 1 && diff <= 2) ? 2'(3 - diff) : 2'd0;
    c = ref_ctrl(op);
    u = ref_uses(op);
    raw = (u[1] && (now - last_wr[ra] <= 4)) || (u[0] && (now - last_wr[rb] <= 4));
    exp_stall = (exp_busy != 2'd0) || raw;
    exp_ctrl  = exp_stall ? 10'd0 : c;
    exp_ill   = ill_m;
    if (!exp_stall) begin
      if (c[7]) last_wr[c[8] ? rd : rb] = now;
      if (op == OPC_BEQ) beq_at = now;
    end
    if (!ref_legal(op)) ill_m = 1'b1;
    now++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.OpFn = 5'($urandom); bus.Ra = 3'($urandom); bus.Rb = 3'($urandom);
      bus.Rd = 3'($urandom); bus.alubeq = 1'($urandom_range(1));
      #1;
      sample();
      now++;
    end
    model_clear();
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", obs_stall); end
    checks++; if (obs_ctrl !== 10'd0) begin errors++; $display("FAIL reset_ctrl: got %b want 0", obs_ctrl); end
    apply(5'd31, 3'd0, 3'd0, 3'd0);
    checks++; if (obs_ill !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", obs_ill); end
    checks++; if (obs_busy !== 2'd0) begin errors++; $display("FAIL reset_busy: got %0d want 0", obs_busy); end
  endtask

  task automatic test_independent();
    apply(5'd0, 3'd1, 3'd2, 3'd3);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL indep_stall1: got %b want 0", obs_stall); end
    apply(5'd0, 3'd4, 3'd6, 3'd5);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL indep_stall2: got %b want 0", obs_stall); end
    checks++; if (obs_ctrl !== CTRL_ADD) begin errors++; $display("FAIL indep_ctrl: got %b want %b", obs_ctrl, CTRL_ADD); end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    int bad_bubble = 0;
    apply(5'd9, 3'd1, 3'd2, 3'd0);
    checks++; if (obs_ctrl !== {7'b0011011, 3'b000}) begin errors++; $display("FAIL lw_ctrl: got %b want 0011011000", obs_ctrl); end
    for (int i = 0; i < 8; i++) begin
      apply(5'd0, 3'd2, 3'd7, 3'd3);
      if (obs_stall !== 1'b1) break;
      stalls++;
      if (obs_ctrl !== 10'd0) bad_bubble++;
    end
    checks++; if (stalls != 4) begin errors++; $display("FAIL load_use_stalls: got %0d want 4", stalls); end
    checks++; if (bad_bubble != 0) begin errors++; $display("FAIL load_use_bubble: got %0d nonzero bubbles want 0", bad_bubble); end
    checks++; if (obs_ctrl !== CTRL_ADD) begin errors++; $display("FAIL load_use_issue: got %b want %b", obs_ctrl, CTRL_ADD); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) apply(5'd31, 3'd0, 3'd0, 3'd0);
    apply(OPC_BEQ, 3'd1, 3'd2, 3'd0);
    checks++; if (obs_ctrl !== 10'b0000000101 || obs_stall !== 1'b0) begin errors++; $display("FAIL beq_issue: got ctrl=%b stall=%b want 0000000101/0", obs_ctrl, obs_stall); end
    apply(5'd0, 3'd1, 3'd2, 3'd4);
    checks++; if (obs_busy !== 2'd2 || obs_stall !== 1'b1) begin errors++; $display("FAIL beq_wait1: got busy=%0d stall=%b want 2/1", obs_busy, obs_stall); end
    apply(5'd0, 3'd1, 3'd2, 3'd4);
    checks++; if (obs_busy !== 2'd1 || obs_stall !== 1'b1) begin errors++; $display("FAIL beq_wait2: got busy=%0d stall=%b want 1/1", obs_busy, obs_stall); end
    apply(5'd0, 3'd1, 3'd2, 3'd4);
    checks++; if (obs_stall !== 1'b0 || obs_ctrl !== CTRL_ADD) begin errors++; $display("FAIL beq_resume: got stall=%b ctrl=%b want 0/%b", obs_stall, obs_ctrl, CTRL_ADD); end
  endtask

  task automatic test_illegal();
    apply(5'b00111, 3'd1, 3'd2, 3'd3);
    checks++; if (obs_ctrl !== 10'd0 || obs_ill !== 1'b0) begin errors++; $display("FAIL illegal_decode: got ctrl=%b illegal=%b want 0/0", obs_ctrl, obs_ill); end
    apply(5'd0, 3'd6, 3'd6, 3'd7);
    checks++; if (obs_ill !== 1'b1) begin errors++; $display("FAIL illegal_set: got %b want 1", obs_ill); end
    for (int i = 0; i < 3; i++) apply(5'd31, 3'd0, 3'd0, 3'd0);
    checks++; if (obs_ill !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b want 1", obs_ill); end
    do_reset(1);
    apply(5'd31, 3'd0, 3'd0, 3'd0);
    checks++; if (obs_ill !== 1'b0) begin errors++; $display("FAIL illegal_clear: got %b want 0", obs_ill); end
  endtask

  task automatic test_reset_mid_stall();
    apply(5'd9, 3'd0, 3'd2, 3'd0);
    apply(5'd0, 3'd2, 3'd1, 3'd4);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %b want 1", obs_stall); end
    do_reset(1);
    checks++; if (obs_stall !== 1'b0 || obs_ctrl !== 10'd0) begin errors++; $display("FAIL mid_in_reset: got stall=%b ctrl=%b want 0/0", obs_stall, obs_ctrl); end
    apply(5'd0, 3'd2, 3'd1, 3'd4);
    checks++; if (obs_stall !== 1'b0 || obs_ctrl !== CTRL_ADD) begin errors++; $display("FAIL mid_after_reset: got stall=%b ctrl=%b want 0/%b", obs_stall, obs_ctrl, CTRL_ADD); end
  endtask

  task automatic test_jump();
    apply(5'd16, 3'd4, 3'd4, 3'd4);
    checks++; if (obs_ctrl[9] !== 1'b1 || obs_ctrl[7] !== 1'b0 || obs_ctrl[5] !== 1'b0 || obs_stall !== 1'b0) begin
      errors++; $display("FAIL jump: got NIA=%b RegWrite=%b MemWrite=%b stall=%b want 1/0/0/0", obs_ctrl[9], obs_ctrl[7], obs_ctrl[5], obs_stall);
    end
    apply(5'd0, 3'd1, 3'd0, 3'd6);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL jump_next: got stall=%b want 0", obs_stall); end
  endtask

  task automatic test_random();
    logic [4:0] op;
    logic [2:0] ra, rb, rd;
    op = 5'd31; ra = 3'd0; rb = 3'd0; rd = 3'd0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(49) == 0) begin
        do_reset(1);
        checks++; if (obs_stall !== 1'b0 || obs_ctrl !== 10'd0) begin errors++; $display("FAIL rand_reset: cycle %0d got stall=%b ctrl=%b want 0/0", n, obs_stall, obs_ctrl); end
        continue;
      end
      if (!obs_stall || rst) begin
        op = ($urandom_range(15) == 0) ? 5'($urandom) : legal_ops[$urandom_range(10)];
        ra = 3'($urandom); rb = 3'($urandom); rd = 3'($urandom);
      end
      apply(op, ra, rb, rd);
      checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rand_stall: cycle %0d op=%b got %b want %b", n, op, obs_stall, exp_stall); end
      checks++; if (obs_busy !== exp_busy) begin errors++; $display("FAIL rand_busy: cycle %0d got %0d want %0d", n, obs_busy, exp_busy); end
      checks++; if (obs_ctrl !== exp_ctrl) begin errors++; $display("FAIL rand_ctrl: cycle %0d op=%b got %b want %b", n, op, obs_ctrl, exp_ctrl); end
      checks++; if (obs_ill !== exp_ill) begin errors++; $display("FAIL rand_illegal: cycle %0d got %b want %b", n, obs_ill, exp_ill); end
    end
  endtask

  initial begin
    bus.OpFn = 5'd31; bus.Ra = 3'd0; bus.Rb = 3'd0; bus.Rd = 3'd0; bus.alubeq = 1'b0;
    obs_stall = 1'b0;
    model_clear();
    test_reset();
    test_independent();
    test_load_use();
    test_branch();
    test_illegal();
    test_reset_mid_stall();
    test_jump();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-002 SHALL expose: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-003 SHALL expose: OpFn in 5, opcode/function from the decoder (stage 1); Ra, Rb, Rd in 3 each, register fields of the same instruction.
REQ-004 SHALL expose: alubeq in 1, branch-equal result from the stage-3 ALU.
REQ-005 SHALL expose: NIA, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg out 1 each; ALUFn out 3; all are stage-1 controls latched by L1.
REQ-006 SHALL expose: stall out 1, PC/IR hold request; illegal out 1, sticky illegal-opcode flag; busy_cnt out 2, remaining branch-wait bubbles.

Function
REQ-007 SHALL decode OpFn combinationally: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLT (RegDst=1, RegWrite=1, ALUFn=000/001/010/011/100).
REQ-008 SHALL decode 01000 ADDI (ALUSrc=1, RegWrite=1, RegDst=0, ALUFn=000); 01001 LW (ADDI controls plus MemRead=1, MemToReg=1); 01010 SW (ALUSrc=1, MemWrite=1, ALUFn=000).
REQ-009 SHALL decode 01011 BEQ (ALUFn=101, no writes); 10000 J (NIA=1, no writes); 11111 NOP (all controls 0).
REQ-010 SHALL treat any other OpFn as NOP and set illegal to 1 on the next edge; illegal holds until rst.
REQ-011 SHALL define destination as Rd when RegDst=1 and Rb when RegDst=0, valid only when RegWrite=1.
REQ-012 SHALL define sources as: R-type, SW and BEQ read Ra and Rb; ADDI and LW read Ra; J and NOP read none.
REQ-013 SHALL keep a 4-entry scoreboard shift register of {valid, dest} covering stages 2-5; it shifts every clk edge, and entry 0 loads the issued instruction's destination (valid=0 on a bubble).
REQ-014 SHALL assert stall combinationally when any used source equals the dest of a valid scoreboard entry; all 3 register fields are compared, including register 0.
REQ-015 SHALL, while stall=1, force every control output to 0 (bubble) and load an invalid entry into the scoreboard; a RAW stall lasts until the producer retires from entry 3 (at most 4 cycles).
REQ-016 SHALL, on issuing BEQ (not stalled), load busy_cnt=2; while busy_cnt!=0, stall=1 and bubbles issue, and busy_cnt decrements each edge.
REQ-017 SHALL ignore alubeq while busy_cnt=0; the PC-select use of alubeq stays in the datapath, so the branch-wait only guarantees no wrong-path instruction issues.
REQ-018 SHALL issue J with no bubble; NIA=1 in the same cycle.
REQ-019 SHALL give busy_cnt precedence over the RAW check; when both conditions hold, stall=1 and busy_cnt still decrements.

Reset
REQ-020 SHALL, at an rst edge, clear the scoreboard to all invalid, busy_cnt=0, and illegal=0.
REQ-021 SHALL hold all control outputs and stall at 0 while rst=1.
REQ-022 SHALL abandon any in-progress stall or branch wait when rst asserts mid-operation; the first instruction after reset issues unstalled.

Structure
REQ-023 SHALL place the opcode constants, ALUFn codes (000 add ... 101 beq-compare), and the scoreboard depth (4) in a shared package used by the decoder, alu and pipeline_ctrl.
REQ-024 SHALL implement the scoreboard and its comparators as one sub-module, hazard_scoreboard; decode and branch-wait logic stay in pipeline_ctrl.
REQ-025 SHALL require the datapath PC and IR to hold when stall=1.

Verification
REQ-026 SHALL verify: ADD r3,r1,r2 then ADD r5,r4,r6 -> stall stays 0; second instruction gives RegDst=1, RegWrite=1, ALUFn=000.
REQ-027 SHALL verify: LW r2 (Rb=2) then ADD using Ra=2 -> stall=1 for exactly 4 cycles with all controls 0, then ADD issues.
REQ-028 SHALL verify: BEQ -> busy_cnt reads 2 then 1, stall=1 for 2 cycles, and the next instruction issues on cycle 3.
REQ-029 SHALL verify: OpFn=00111 -> all controls 0, and illegal=1 from the next cycle through a later valid ADD, cleared only by rst.
REQ-030 SHALL verify: rst pulse for 1 cycle during a RAW stall -> next cycle stall=0, scoreboard empty, and a dependent instruction issues immediately.
REQ-031 SHALL verify: J (OpFn=10000) -> NIA=1, RegWrite=0, MemWrite=0, stall=0.
